// File: rtl/joy_chain_pkg.sv
// Shared types and constants for the serial joystick chain scanner.
package joy_chain_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, LOW, HIGH, COMMIT} joy_state_e;

  function automatic int chain_len(input int channels, input int bits_per_ch);
    return channels * bits_per_ch;
  endfunction

  // Cycles between successive commits while enable is held high.
  function automatic int frame_period(input int channels, input int bits_per_ch,
                                      input int clk_div);
    return (2 * chain_len(channels, bits_per_ch) + 2) * clk_div;
  endfunction

endpackage

// File: rtl/joy_tick_gen.sv
// Free-running prescaler: o_tick is high for one clock every CLK_DIV clocks.
module joy_tick_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       r_cnt <= '0;
    else if (o_tick) r_cnt <= '0;
    else             r_cnt <= r_cnt + CW'(1);
  end

endmodule

// File: rtl/joy_chain_scanner.sv
// Master for the DB9/JAMMA serial joystick chain: drives load/clock, shifts in
// active-low buttons, commits an active-high frame. Optional JOY_CHAIN_DEBOUNCE_EN.
module joy_chain_scanner
  import joy_chain_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int BITS_PER_CH = 12,
  parameter int CLK_DIV     = 16
) (
  input  logic                            clk_sys,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            joy_data,
  output logic                            joy_clk,
  output logic                            joy_load,
  output logic [CHANNELS*BITS_PER_CH-1:0] joy_out,
  output logic                            frame_valid,
  output logic [7:0]                      frame_cnt
);

  localparam int N  = chain_len(CHANNELS, BITS_PER_CH);
  localparam int BW = $clog2(N + 1);

  logic w_tick;

  joy_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .i_clk (clk_sys),
    .i_rst (reset),
    .o_tick(w_tick)
  );

  joy_state_e    r_state, w_state_nxt;
  logic          r_clk, r_load, w_clk_nxt, w_load_nxt;
  logic          w_shift, w_commit;
  logic [N-1:0]  r_shreg, r_out, w_raw, w_out_nxt;
  logic [BW-1:0] r_bitcnt;
  logic          r_fv;
  logic [7:0]    r_fcnt;

  always_comb begin
    w_state_nxt = r_state;
    w_clk_nxt   = r_clk;
    w_load_nxt  = r_load;
    w_shift     = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: if (w_tick && enable) begin
        w_load_nxt  = 1'b0;
        w_state_nxt = LOAD;
      end
      LOAD: if (w_tick) begin
        w_load_nxt  = 1'b1;
        w_state_nxt = LOW;
      end
      LOW: if (w_tick) begin
        w_shift     = 1'b1;
        w_clk_nxt   = 1'b1;
        w_state_nxt = HIGH;
      end
      HIGH: if (w_tick) begin
        w_clk_nxt   = 1'b0;
        w_state_nxt = (r_bitcnt == BW'(N)) ? COMMIT : LOW;
      end
      COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_load_nxt  = 1'b1;
        w_clk_nxt   = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_clk   <= 1'b0;
      r_load  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_clk   <= w_clk_nxt;
      r_load  <= w_load_nxt;
    end
  end

  // Chain bits are active-low; first bit shifted in ends up at the MSB.
  assign w_raw = ~r_shreg;

`ifdef JOY_CHAIN_DEBOUNCE_EN
  logic [N-1:0] r_prev;
  logic [N-1:0] w_same;

  assign w_same    = ~(w_raw ^ r_prev);
  assign w_out_nxt = (r_out & ~w_same) | (w_raw & w_same);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)         r_prev <= '0;
    else if (w_commit) r_prev <= w_raw;
  end
`else
  assign w_out_nxt = w_raw;
`endif

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_out    <= '0;
      r_fv     <= 1'b0;
      r_fcnt   <= '0;
    end else begin
      r_fv <= w_commit;
      if (w_shift) begin
        r_shreg  <= {r_shreg[N-2:0], joy_data};
        r_bitcnt <= r_bitcnt + BW'(1);
      end
      if (w_commit) begin
        r_out    <= w_out_nxt;
        r_bitcnt <= '0;
        r_fcnt   <= r_fcnt + 8'd1;
      end
    end
  end

  assign joy_clk     = r_clk;
  assign joy_load    = r_load;
  assign joy_out     = r_out;
  assign frame_valid = r_fv;
  assign frame_cnt   = r_fcnt;

endmodule

// File: doc/joy_chain_scanner.md
Name: joy_chain_scanner

Overview:
- Native master for the DB9/JAMMA serial joystick chain. Replaces the plain pin-reflection path (JOY_CLK/JOY_LOAD/JOY_DATA) in board top levels.
- Generates the shift-register load and clock itself and deserialises CHANNELS × BITS_PER_CH active-low button bits. Outputs them as a latched, active-high vector with a per-frame strobe.
- Sits in the board top, between the joystick pins and the core's input mapping.

Parameters:
CHANNELS, 2, number of players/controllers daisy-chained
BITS_PER_CH, 12, button bits per controller
CLK_DIV, 16, clk_sys cycles per half joy_clk period; minimum 3
N (localparam), CHANNELS*BITS_PER_CH, total chain length

Ports:
clk_sys  in  1  system clock; the only clock
reset  in  1  asynchronous, active-high reset
enable  in  1  start/continue scanning frames
joy_data  in  1  serial data from chain, active-low buttons
joy_clk  out  1  chain shift clock
joy_load  out  1  chain parallel load, active-low
joy_out  out  N  debounced/latched buttons, active-high; channel c at [c*BITS_PER_CH +: BITS_PER_CH]
frame_valid  out  1  one-cycle pulse when joy_out updates
frame_cnt  out  8  completed-frame counter, wraps 255→0

Behaviour:
- Reset values (asynchronous): joy_clk=0, joy_load=1, joy_out=0, frame_valid=0, frame_cnt=0, state=IDLE, prescaler=0, bit_cnt=0.
- Prescaler:
  - Free-running 0..CLK_DIV-1; tick=1 when the count equals CLK_DIV-1.
  - After reset release, tick k occurs on clock edge k*CLK_DIV.
- FSM, all outputs registered:
  - IDLE: joy_load=1, joy_clk=0. On tick with enable=1 → LOAD.
  - LOAD: joy_load=0 for one tick period. On tick, joy_load←1 → LOW.
  - LOW (joy_clk=0): on tick, sample joy_data, shift register ← {shreg[N-2:0], joy_data}, bit_cnt++, joy_clk←1 → HIGH.
  - HIGH: on tick, joy_clk←0. If bit_cnt==N → COMMIT, else → LOW.
  - COMMIT (one cycle): joy_out←~shreg, frame_valid=1, frame_cnt++, bit_cnt←0 → IDLE.
- Bit ordering: the first bit received lands in joy_out[N-1]; the last bit received is joy_out[0].
- Frame period with enable held high: exactly (2N+2)*CLK_DIV cycles. frame_valid is asserted on edge (2N+2)*CLK_DIV+1 after reset release.
- enable deasserted mid-frame: the current frame completes and commits, then the FSM stays in IDLE. joy_out holds its value.
- enable asserted in IDLE: the frame starts on the next tick. There is no partial-tick start.
- Reset mid-frame: immediate abort. Outputs return to reset values; the partial shift data is discarded.
- frame_valid never asserts for two consecutive cycles.

Optional Feature:
- Macro: JOY_CHAIN_DEBOUNCE_EN.
- Defined:
  - Each committed raw frame is compared with the previous raw frame, held in an N-bit register that resets to 0.
  - joy_out[i] updates only when raw bit i is equal in two consecutive frames; otherwise the old value is held.
  - frame_valid still pulses every frame.
  - Press latency is two frames.
- Undefined: joy_out ← raw frame directly, with one-frame latency. No extra registers.

Decomposition:
- Package joy_chain_pkg contains:
  - the state enum {IDLE, LOAD, LOW, HIGH, COMMIT};
  - the function computing N;
  - the frame-period constant function (2N+2)*CLK_DIV, for the bench.
- One sub-module, joy_tick_gen: the parametrised prescaler producing tick.
- The FSM, shift register and debounce stay in the top of the block.

Test Plan:
- Reset-release timing (CHANNELS=2, BITS=12, CLK_DIV=4, enable=1, joy_data=1): joy_load is low from edge 4 to 8; the first joy_clk rise is at edge 12; 24 rising joy_clk edges occur; frame_valid is high on edge 201; joy_out=0.
- Pattern frame (chain model drives 0xA5C3F0, active-low): joy_out=0x5A3C0F after the first frame_valid. channel0=0xC0F, channel1=0x5A3.
- Steady enable: successive frame_valid pulses are exactly 200 cycles apart; frame_cnt reaches 0 again after 256 frames.
- enable dropped at cycle 100: the frame still commits at 201; no further joy_load pulses; joy_out held.
- Reset asserted at cycle 150 for 3 cycles: joy_clk=0, joy_load=1, joy_out=0 immediately. After release the full timing restarts from edge 0.
- JOY_CHAIN_DEBOUNCE_EN: button bit 0 is pressed for one frame only, so joy_out[0] stays 0. When pressed for two frames, joy_out[0]=1 after the second frame_valid. With the macro undefined, joy_out[0]=1 after the first frame.
